test_xil_dip_sink: RTL and testbench

Consumer end of the DIP test word handshake. It raises `rdy_for_data`, captures the 32-bit word when `data_rdy` pulses, and checks the fixed low-24-bit tag. It drives the captured DIP byte onto LEDs, then withdraws and re-raises the request. It is used on the board to close the loop with the DIP-switch word source and to give visible pass/fail status.

---
 rtl/test_xil_dip_sink.sv | 114 +++++++++++
 tb/tb_test_xil_dip_sink.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/test_xil_dip_sink.sv
// Consumer end of the DIP test word handshake: requests a word, captures it, checks the
// fixed low-24-bit tag and shows the DIP byte on the LEDs, with sticky error/timeout flags.
module test_xil_dip_sink #(
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 1023,
   parameter logic [23:0] TAG        = 24'h123456
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        data_rdy,
   input  logic [31:0] data_in,
   output logic        rdy_for_data,
   output logic [7:0]  leds,
   output logic        new_word,
   output logic [15:0] word_cnt,
   output logic        tag_err,
   output logic        timeout
);

   typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

   localparam logic [3:0]  GapLast  = 4'(GAP_CYCLES - 1);
   localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [3:0]  gap_cnt_q, gap_cnt_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        rdy_q, rdy_d;
   logic [7:0]  leds_q, leds_d;
   logic        new_word_q, new_word_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic        tag_err_q, tag_err_d;
   logic        timeout_q, timeout_d;
   logic        capture;
   logic        expire;

   // Capture beats both the enable drop and timeout expiry in the same cycle.
   always_comb begin
      capture = (state_q == StReq) && data_rdy;
      expire  = (state_q == StReq) && enable && !data_rdy && (wait_cnt_q == WaitLast);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         gap_cnt_q  <= '0;
         wait_cnt_q <= '0;
         rdy_q      <= 1'b0;
         leds_q     <= '0;
         new_word_q <= 1'b0;
         word_cnt_q <= '0;
         tag_err_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         rdy_q      <= rdy_d;
         leds_q     <= leds_d;
         new_word_q <= new_word_d;
         word_cnt_q <= word_cnt_d;
         tag_err_q  <= tag_err_d;
         timeout_q  <= timeout_d;
      end
   end

   // Counters default to zero so they are clear on every state entry.
   always_comb begin
      state_d    = state_q;
      gap_cnt_d  = '0;
      wait_cnt_d = '0;
      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StReq;
         end
         StReq: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (data_rdy || expire) begin
               state_d = StGap;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         StGap: begin
            if (gap_cnt_q == GapLast) begin
               state_d = enable ? StReq : StIdle;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rdy_d      = (state_d == StReq);
      leds_d     = capture ? data_in[31:24] : leds_q;
      new_word_d = capture;
      word_cnt_d = word_cnt_q;
      if (capture && (word_cnt_q != 16'hFFFF)) word_cnt_d = word_cnt_q + 16'd1;
      tag_err_d  = tag_err_q | (capture && (data_in[23:0] != TAG));
      timeout_d  = timeout_q | expire;
   end

   assign rdy_for_data = rdy_q;
   assign leds         = leds_q;
   assign new_word     = new_word_q;
   assign word_cnt     = word_cnt_q;
   assign tag_err      = tag_err_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_test_xil_dip_sink.sv
// Bench for test_xil_dip_sink: word table plus hand sequences for gap, timeout, ignore and reset.
module tb_test_xil_dip_sink;

   localparam logic [23:0] Tag = 24'h123456;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        data_rdy = 1'b0;
   logic [31:0] data_in = '0;
   logic        rdy_for_data;
   logic [7:0]  leds;
   logic        new_word;
   logic [15:0] word_cnt;
   logic        tag_err;
   logic        timeout;

   test_xil_dip_sink #(
      .GAP_CYCLES (2),
      .TIMEOUT    (8),
      .TAG        (Tag)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .data_rdy     (data_rdy),
      .data_in      (data_in),
      .rdy_for_data (rdy_for_data),
      .leds         (leds),
      .new_word     (new_word),
      .word_cnt     (word_cnt),
      .tag_err      (tag_err),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  exp_leds;
      logic        exp_tag;
   } vec_t;

   typedef struct {
      logic [7:0]  leds;
      logic [15:0] cnt;
      logic        tag;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_nw = -1;
   bit          chk_space = 0;
   logic [15:0] m_cnt = '0;
   logic        m_tag = 1'b0;
   logic [7:0]  m_leds = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard: every new_word pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (new_word === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_new_word", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_leds", 32'(leds), 32'(e.leds));
            chk("sb_word_cnt", 32'(word_cnt), 32'(e.cnt));
            chk("sb_tag_err", 32'(tag_err), 32'(e.tag));
            chk("sb_rdy_low", 32'(rdy_for_data), 32'd0);
         end
         if (chk_space && last_nw >= 0) chk("pulse_spacing", 32'(cyc - last_nw), 32'd3);
         last_nw = cyc;
      end
   end

   task automatic wait_rdy(input string name);
      int i;
      for (i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rdy_for_data === 1'b1) break;
      end
      if (i == 50) chk(name, 32'(rdy_for_data), 32'd1);
   endtask

   // Answers in the first REQ cycle, like the board source.
   task automatic send_word(input logic [31:0] d);
      exp_t e;
      wait_rdy("wait_rdy_send");
      data_in  = d;
      data_rdy = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_tag  = m_tag | (d[23:0] != Tag);
      m_leds = d[31:24];
      e.leds = m_leds;
      e.cnt  = m_cnt;
      e.tag  = m_tag;
      sb.push_back(e);
      @(posedge clk);
      #1 data_rdy = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rdy"}, 32'(rdy_for_data), 32'd0);
      chk({tag, "_leds"}, 32'(leds), 32'd0);
      chk({tag, "_new_word"}, 32'(new_word), 32'd0);
      chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
      chk({tag, "_tag_err"}, 32'(tag_err), 32'd0);
      chk({tag, "_timeout"}, 32'(timeout), 32'd0);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{32'h01123456, 8'h01, 1'b0};
      vecs[1] = '{32'h02123456, 8'h02, 1'b0};
      vecs[2] = '{32'h04123456, 8'h04, 1'b0};
      vecs[3] = '{32'h08123456, 8'h08, 1'b0};
      vecs[4] = '{32'hFF123456, 8'hFF, 1'b0};
      vecs[5] = '{32'h3C123457, 8'h3C, 1'b1};
      vecs[6] = '{32'h77123456, 8'h77, 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst_n  = 1'b1;
      enable = 1'b1;

      // First word: request high one cycle, then low for two
      chk_space = 1;
      send_word(32'hA5123456);
      @(negedge clk);
      chk("first_gap1_rdy", 32'(rdy_for_data), 32'd0);
      @(negedge clk);
      chk("first_gap2_rdy", 32'(rdy_for_data), 32'd0);
      chk("first_gap2_new_word", 32'(new_word), 32'd0);

      // Back-to-back table words
      for (int i = 0; i < 7; i++) begin
         send_word(vecs[i].data);
         @(negedge clk);
         chk($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
         chk($sformatf("vec%0d_tag_err", i), 32'(tag_err), 32'(vecs[i].exp_tag));
         if (i == 4) chk("five_words_cnt", 32'(word_cnt), 32'd6);
      end
      chk_space = 0;

      // Silent source: timeout after exactly 8 REQ cycles
      wait_rdy("wait_rdy_timeout");
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("to_wait%0d", i), {30'd0, rdy_for_data, timeout}, 32'd2);
      end
      @(negedge clk);
      chk("to_set", {30'd0, rdy_for_data, timeout}, 32'd1);
      @(negedge clk);
      chk("to_gap2_rdy", 32'(rdy_for_data), 32'd0);
      @(negedge clk);
      chk("to_rerequest", 32'(rdy_for_data), 32'd1);
      chk("to_word_cnt", 32'(word_cnt), 32'(m_cnt));

      // enable drops in the same cycle as data_rdy: word still captured
      enable   = 1'b0;
      data_in  = 32'h5A123456;
      data_rdy = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_leds = 8'h5A;
      sb.push_back('{8'h5A, m_cnt, m_tag});
      @(posedge clk);
      #1 data_rdy = 1'b0;
      @(negedge clk);
      chk("endrop_cap_rdy", 32'(rdy_for_data), 32'd0);

      // data_rdy in IDLE is ignored
      data_in  = 32'hEE123456;
      data_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("idle_ign%0d", i), {30'd0, rdy_for_data, new_word}, 32'd0);
      end
      data_rdy = 1'b0;
      chk("idle_ign_cnt", 32'(word_cnt), 32'(m_cnt));
      chk("idle_ign_leds", 32'(leds), 32'(m_leds));

      // data_rdy in GAP is ignored
      enable = 1'b1;
      send_word(32'h11123456);
      @(negedge clk);
      data_in  = 32'hEE123456;
      data_rdy = 1'b1;
      @(negedge clk);
      chk("gap_ign_new_word", 32'(new_word), 32'd0);
      @(negedge clk);
      chk("gap_ign_req", {30'd0, rdy_for_data, new_word}, 32'd2);
      data_rdy = 1'b0;
      chk("gap_ign_cnt", 32'(word_cnt), 32'(m_cnt));
      chk("gap_ign_leds", 32'(leds), 32'h11);

      // enable drops in REQ: request withdrawn next edge and stays low
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("endrop_idle%0d", i), 32'(rdy_for_data), 32'd0);
      end

      // Reset mid-REQ after 3 words
      enable = 1'b1;
      for (int i = 0; i < 3; i++) send_word(32'h40123456 + (32'(i) << 24));
      wait_rdy("wait_rdy_reset");
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("midreset");
      m_cnt  = '0;
      m_tag  = 1'b0;
      m_leds = '0;
      send_word(32'hC3123456);
      @(negedge clk);
      chk("post_reset_cnt", 32'(word_cnt), 32'd1);
      chk("post_reset_leds", 32'(leds), 32'hC3);
      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
